// File: rtl/fetch_if.sv
// Fetch-side bus bundle: control inputs from the core, the instruction BRAM
// port, and the {pc, inst, valid} stream presented to decode.
//   master : the fetch sequencer (drives imem_en/imem_addr and the if_* outputs)
//   slave  : the surroundings (control, BRAM data, decode)
interface fetch_if #(
    parameter int unsigned PC_WIDTH   = 32,
    parameter int unsigned INST_WIDTH = 32
);
    logic                  work_ena;
    logic                  stall;
    logic                  pc_jump;
    logic [PC_WIDTH-1:0]   pc_target;
    logic                  imem_en;
    logic [PC_WIDTH-1:0]   imem_addr;
    logic [INST_WIDTH-1:0] imem_rdata;
    logic [PC_WIDTH-1:0]   if_pc;
    logic [INST_WIDTH-1:0] if_inst;
    logic                  if_valid;

    modport master (
        input  work_ena, stall, pc_jump, pc_target, imem_rdata,
        output imem_en, imem_addr, if_pc, if_inst, if_valid
    );

    modport slave (
        output work_ena, stall, pc_jump, pc_target, imem_rdata,
        input  imem_en, imem_addr, if_pc, if_inst, if_valid
    );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller. Owns the PC, issues reads to a 1-cycle
// synchronous BRAM and presents PC-matched instructions to decode. A 1-entry
// skid buffer catches the read in flight when decode stalls; a jump flushes
// everything in flight; work_ena low returns to idle at RESET_PC.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : fetch_if.master (work_ena, stall, pc_jump, pc_target,
//              imem_en, imem_addr, imem_rdata, if_pc, if_inst, if_valid)
module fetch_sequencer #(
    parameter int unsigned          PC_WIDTH   = 32,
    parameter int unsigned          INST_WIDTH = 32,
    parameter int unsigned          PC_STEP    = 4,
    parameter logic [PC_WIDTH-1:0]  RESET_PC   = '0
) (
    input  logic     clk,
    input  logic     rst,
    fetch_if.master  bus
);

    typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

    state_t                state_q, state_d;
    logic [PC_WIDTH-1:0]   fetch_pc_q, fetch_pc_d;
    logic                  inflight_v_q, inflight_v_d;
    logic [PC_WIDTH-1:0]   inflight_pc_q, inflight_pc_d;
    logic                  skid_v_q, skid_v_d;
    logic [PC_WIDTH-1:0]   skid_pc_q, skid_pc_d;
    logic [INST_WIDTH-1:0] skid_inst_q, skid_inst_d;
    logic [PC_WIDTH-1:0]   if_pc_q, if_pc_d;
    logic [INST_WIDTH-1:0] if_inst_q, if_inst_d;
    logic                  if_valid_q, if_valid_d;
    logic                  imem_en;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            fetch_pc_q    <= RESET_PC;
            inflight_v_q  <= 1'b0;
            inflight_pc_q <= '0;
            skid_v_q      <= 1'b0;
            skid_pc_q     <= '0;
            skid_inst_q   <= '0;
            if_pc_q       <= '0;
            if_inst_q     <= '0;
            if_valid_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            inflight_v_q  <= inflight_v_d;
            inflight_pc_q <= inflight_pc_d;
            skid_v_q      <= skid_v_d;
            skid_pc_q     <= skid_pc_d;
            skid_inst_q   <= skid_inst_d;
            if_pc_q       <= if_pc_d;
            if_inst_q     <= if_inst_d;
            if_valid_q    <= if_valid_d;
        end
    end

    // Next state and BRAM enable; priority rst > !work_ena > jump > stall > run
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        inflight_v_d  = inflight_v_q;
        inflight_pc_d = inflight_pc_q;
        skid_v_d      = skid_v_q;
        skid_pc_d     = skid_pc_q;
        skid_inst_d   = skid_inst_q;
        if_pc_d       = if_pc_q;
        if_inst_d     = if_inst_q;
        if_valid_d    = if_valid_q;
        imem_en       = 1'b0;

        if (rst || !bus.work_ena) begin
            state_d      = IDLE;
            fetch_pc_d   = RESET_PC;
            inflight_v_d = 1'b0;
            skid_v_d     = 1'b0;
            if_pc_d      = '0;
            if_inst_d    = '0;
            if_valid_d   = 1'b0;
        end else if (state_q == IDLE) begin
            state_d = RUN;
        end else if (bus.pc_jump) begin
            // Flush: nothing fetched before the jump may reach decode
            state_d      = RUN;
            fetch_pc_d   = bus.pc_target;
            inflight_v_d = 1'b0;
            skid_v_d     = 1'b0;
            if_valid_d   = 1'b0;
        end else if (bus.stall) begin
            // Issue stops, so at most one read (last cycle's) needs parking
            state_d = STALL;
            if (inflight_v_q) begin
                skid_v_d    = 1'b1;
                skid_pc_d   = inflight_pc_q;
                skid_inst_d = bus.imem_rdata;
            end
            inflight_v_d = 1'b0;
        end else begin
            state_d       = RUN;
            imem_en       = 1'b1;
            fetch_pc_d    = fetch_pc_q + PC_WIDTH'(PC_STEP);
            inflight_v_d  = 1'b1;
            inflight_pc_d = fetch_pc_q;
            if (skid_v_q) begin
                if_pc_d    = skid_pc_q;
                if_inst_d  = skid_inst_q;
                if_valid_d = 1'b1;
                skid_v_d   = 1'b0;
            end else if (inflight_v_q) begin
                if_pc_d    = inflight_pc_q;
                if_inst_d  = bus.imem_rdata;
                if_valid_d = 1'b1;
            end else begin
                if_valid_d = 1'b0;
            end
        end
    end

    assign bus.imem_en   = imem_en;
    assign bus.imem_addr = fetch_pc_q;
    assign bus.if_pc     = if_pc_q;
    assign bus.if_inst   = if_inst_q;
    assign bus.if_valid  = if_valid_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus a randomized run, all
// checked against a transaction-level model (queue of issued-but-unpresented
// addresses, instruction = address ^ K).
module tb_fetch_sequencer;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic clk = 1'b0;
    logic rst;

    fetch_if #(.PC_WIDTH(32), .INST_WIDTH(32)) bus_if ();

    fetch_sequencer #(
        .PC_WIDTH(32), .INST_WIDTH(32), .PC_STEP(4), .RESET_PC(32'h0)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    always #5 clk = ~clk;

    // Synchronous BRAM, 1-cycle latency
    always @(posedge clk) begin
        if (bus_if.imem_en) bus_if.imem_rdata <= bus_if.imem_addr ^ K;
    end

    int vectors    = 0;
    int miscompares = 0;

    // Reference model
    logic [31:0] m_next_pc;
    logic [31:0] m_pend[$];
    bit          m_run;
    bit          m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    // Observed / expected BRAM request in the cycle before the last edge
    logic        seen_en;
    logic [31:0] seen_addr;
    bit          exp_en;
    logic [31:0] exp_addr;

    task automatic m_clear();
        m_pend.delete();
        m_next_pc = 32'h0;
        m_run     = 0;
        m_valid   = 0;
        m_pc      = 32'h0;
        m_inst    = 32'h0;
    endtask

    // Drive one cycle of inputs, advance one edge, advance the model
    task automatic step(input logic r, input logic e, input logic j,
                        input logic [31:0] t, input logic s);
        rst              = r;
        bus_if.work_ena  = e;
        bus_if.pc_jump   = j;
        bus_if.pc_target = t;
        bus_if.stall     = s;
        #1;
        seen_en   = bus_if.imem_en;
        seen_addr = bus_if.imem_addr;
        exp_en    = m_run && e && !r && !j && !s;
        exp_addr  = m_next_pc;
        @(posedge clk);
        #1;
        if (r || !e) begin
            m_clear();
        end else if (!m_run) begin
            m_run = 1;
        end else if (j) begin
            m_pend.delete();
            m_next_pc = t;
            m_valid   = 0;
        end else if (!s) begin
            if (m_pend.size() > 0) begin
                m_pc    = m_pend.pop_front();
                m_inst  = m_pc ^ K;
                m_valid = 1;
            end else begin
                m_valid = 0;
            end
            m_pend.push_back(m_next_pc);
            m_next_pc = m_next_pc + 32'd4;
        end
    endtask

    task automatic restart();
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    endtask

    // Run the stream until the model presents pc; ok=0 if the budget expires
    task automatic run_to_pc(input logic [31:0] pc, output bit ok);
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
            if (m_valid && m_pc == pc) ok = 1;
        end
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b0);
        vectors++;
        if ({bus_if.if_valid, bus_if.if_pc, bus_if.if_inst} !== 65'h0) begin
            miscompares++;
            $display("FAIL reset_outputs got v=%b pc=%h inst=%h exp all 0",
                     bus_if.if_valid, bus_if.if_pc, bus_if.if_inst);
        end
        vectors++;
        if (seen_en !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_imem_en got %b exp 0", seen_en);
        end
    endtask

    task automatic test_startup();
        restart();
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
            vectors++;
            if (bus_if.if_valid !== (i >= 2)) begin
                miscompares++;
                $display("FAIL startup_valid edge %0d got %b exp %b", i, bus_if.if_valid, (i >= 2));
            end
            if (i >= 2) begin
                vectors++;
                if (bus_if.if_pc !== 32'((i - 2) * 4) || bus_if.if_inst !== (32'((i - 2) * 4) ^ K)) begin
                    miscompares++;
                    $display("FAIL startup_pc edge %0d got pc=%h inst=%h exp pc=%h", i,
                             bus_if.if_pc, bus_if.if_inst, 32'((i - 2) * 4));
                end
            end
        end
    endtask

    task automatic test_stall();
        bit ok;
        restart();
        run_to_pc(32'h8, ok);
        vectors++;
        if (!ok || bus_if.if_pc !== 32'h8) begin
            miscompares++;
            $display("FAIL stall_reach got pc=%h ok=%0d exp pc=8", bus_if.if_pc, ok);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
            vectors++;
            if ({bus_if.if_valid, bus_if.if_pc, bus_if.if_inst, seen_en} !== {1'b1, 32'h8, 32'h8 ^ K, 1'b0}) begin
                miscompares++;
                $display("FAIL stall_hold cyc %0d got v=%b pc=%h inst=%h en=%b exp v=1 pc=8 en=0",
                         i, bus_if.if_valid, bus_if.if_pc, bus_if.if_inst, seen_en);
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
            vectors++;
            if ({bus_if.if_valid, bus_if.if_pc, bus_if.if_inst} !==
                {1'b1, 32'(12 + 4 * i), 32'(12 + 4 * i) ^ K}) begin
                miscompares++;
                $display("FAIL stall_release cyc %0d got v=%b pc=%h exp pc=%h",
                         i, bus_if.if_valid, bus_if.if_pc, 32'(12 + 4 * i));
            end
        end
    endtask

    task automatic test_jump(input bit with_stall, input logic [31:0] tgt);
        bit ok;
        restart();
        run_to_pc(32'h8, ok);
        vectors++;
        if (!ok || bus_if.if_pc !== 32'h8) begin
            miscompares++;
            $display("FAIL jump_reach got pc=%h ok=%0d exp pc=8", bus_if.if_pc, ok);
        end
        if (with_stall) begin
            step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
            step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        end
        step(1'b0, 1'b1, 1'b1, tgt, with_stall);
        vectors++;
        if (bus_if.if_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL jump_edge_k stall=%0d got v=%b exp 0", with_stall, bus_if.if_valid);
        end
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        vectors++;
        if ({bus_if.if_valid, seen_en, seen_addr} !== {1'b0, 1'b1, tgt}) begin
            miscompares++;
            $display("FAIL jump_edge_k1 stall=%0d got v=%b en=%b addr=%h exp v=0 en=1 addr=%h",
                     with_stall, bus_if.if_valid, seen_en, seen_addr, tgt);
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
            vectors++;
            if ({bus_if.if_valid, bus_if.if_pc, bus_if.if_inst} !==
                {1'b1, tgt + 32'(4 * i), (tgt + 32'(4 * i)) ^ K}) begin
                miscompares++;
                $display("FAIL jump_target stall=%0d cyc %0d got v=%b pc=%h exp pc=%h",
                         with_stall, i, bus_if.if_valid, bus_if.if_pc, tgt + 32'(4 * i));
            end
        end
    endtask

    task automatic test_work_ena();
        bit ok;
        restart();
        run_to_pc(32'h8, ok);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
            vectors++;
            if (bus_if.if_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL ena_low cyc %0d got v=%b exp 0", i, bus_if.if_valid);
            end
        end
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
            vectors++;
            if (bus_if.if_valid !== (i >= 2) || (i >= 2 && bus_if.if_pc !== 32'((i - 2) * 4))) begin
                miscompares++;
                $display("FAIL ena_restart edge %0d got v=%b pc=%h exp v=%b pc=%h", i,
                         bus_if.if_valid, bus_if.if_pc, (i >= 2), 32'((i - 2) * 4));
            end
        end
    endtask

    task automatic test_rst_in_stall();
        bit ok;
        restart();
        run_to_pc(32'h8, ok);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
        vectors++;
        if ({bus_if.if_valid, bus_if.if_pc, bus_if.if_inst} !== 65'h0) begin
            miscompares++;
            $display("FAIL rst_stall_clear got v=%b pc=%h inst=%h exp all 0",
                     bus_if.if_valid, bus_if.if_pc, bus_if.if_inst);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        ok = 0;
        for (int i = 0; i < 6 && !ok; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
            if (bus_if.if_valid === 1'b1) ok = 1;
        end
        vectors++;
        if (!ok || bus_if.if_pc !== 32'h0 || bus_if.if_inst !== K) begin
            miscompares++;
            $display("FAIL rst_stall_first got ok=%0d pc=%h inst=%h exp pc=0", ok, bus_if.if_pc, bus_if.if_inst);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        restart();
        run_to_pc(32'h4, ok);
        step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        vectors++;
        if ({bus_if.if_valid, bus_if.if_pc} !== {1'b1, 32'hFFFF_FFFC}) begin
            miscompares++;
            $display("FAIL wrap_last got v=%b pc=%h exp pc=fffffffc", bus_if.if_valid, bus_if.if_pc);
        end
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
        vectors++;
        if ({bus_if.if_valid, bus_if.if_pc, bus_if.if_inst} !== {1'b1, 32'h0, K}) begin
            miscompares++;
            $display("FAIL wrap_zero got v=%b pc=%h inst=%h exp pc=0", bus_if.if_valid, bus_if.if_pc, bus_if.if_inst);
        end
    endtask

    task automatic test_random();
        logic r, e, j, s;
        logic [31:0] t;
        restart();
        for (int i = 0; i < 600; i++) begin
            r = ($urandom_range(0, 99) == 0);
            e = ($urandom_range(0, 39) != 0);
            j = ($urandom_range(0, 14) == 0);
            s = ($urandom_range(0, 2) == 0);
            t = $urandom() & 32'hFFFF_FFFC;
            step(r, e, j, t, s);
            vectors++;
            if (seen_en !== exp_en || (exp_en && seen_addr !== exp_addr)) begin
                miscompares++;
                $display("FAIL rand_imem cyc %0d got en=%b addr=%h exp en=%b addr=%h",
                         i, seen_en, seen_addr, exp_en, exp_addr);
            end
            vectors++;
            if (bus_if.if_valid !== m_valid ||
                (m_valid && (bus_if.if_pc !== m_pc || bus_if.if_inst !== m_inst))) begin
                miscompares++;
                $display("FAIL rand_out cyc %0d got v=%b pc=%h inst=%h exp v=%b pc=%h inst=%h",
                         i, bus_if.if_valid, bus_if.if_pc, bus_if.if_inst, m_valid, m_pc, m_inst);
            end
        end
    endtask

    initial begin
        rst              = 1'b1;
        bus_if.work_ena  = 1'b0;
        bus_if.stall     = 1'b0;
        bus_if.pc_jump   = 1'b0;
        bus_if.pc_target = 32'h0;
        m_clear();
        @(posedge clk);
        #1;
        test_reset();
        test_startup();
        test_stall();
        test_jump(1'b0, 32'h100);
        test_jump(1'b1, 32'h200);
        test_work_ena();
        test_rst_in_stall();
        test_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Instruction-fetch controller that owns the program counter.
- Drives a synchronous instruction BRAM with 1-cycle read latency: address registered at the edge, data valid in the following cycle.
- Delivers PC-matched {pc, instruction, valid} to decode.
- Handles stall with a 1-entry skid buffer, redirects on jump with in-flight flush, and gates fetch with work_ena.

Parameters:
- PC_WIDTH, 32, width of all PC/address signals.
- INST_WIDTH, 32, instruction word width.
- PC_STEP, 4, PC increment per sequential fetch.
- RESET_PC, 0, PC loaded on rst and while work_ena is low.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- work_ena  in  1  fetch enable; low forces idle.
- stall  in  1  decode not accepting; the if_* outputs must hold.
- pc_jump  in  1  redirect request, sampled at the edge.
- pc_target  in  PC_WIDTH  redirect address.
- imem_en  out  1  BRAM read enable (combinational from state).
- imem_addr  out  PC_WIDTH  BRAM address; equals fetch_pc register.
- imem_rdata  in  INST_WIDTH  BRAM data for the address issued in the previous cycle.
- if_pc  out  PC_WIDTH  PC of the presented instruction (registered).
- if_inst  out  INST_WIDTH  presented instruction (registered).
- if_valid  out  1  if_pc/if_inst valid (registered).

Behaviour:
- Internal state:
  - fetch_pc.
  - inflight_v / inflight_pc: a read was issued last cycle.
  - skid_v / skid_pc / skid_inst.
  - FSM IDLE / RUN / STALL.
- Priority at each edge: rst > !work_ena > pc_jump > stall > normal.
- rst:
  - fetch_pc=RESET_PC; inflight_v=0, skid_v=0.
  - if_valid=0, if_pc=0, if_inst=0.
  - state=IDLE.
  - Applies mid-stall or mid-flush; any skid contents are discarded.
- IDLE:
  - imem_en=0.
  - If work_ena=0: same clearing as rst and stay IDLE.
  - If work_ena=1: go to RUN at the next edge.
  - First if_valid=1 (if_pc=RESET_PC) appears 2 edges after the first RUN edge: issue at edge 1, present at edge 2.
- RUN, stall=0:
  - imem_en=1, imem_addr=fetch_pc.
  - At the edge:
    - fetch_pc+=PC_STEP, wrapping modulo 2^PC_WIDTH.
    - inflight_v=1, inflight_pc=fetch_pc.
    - If skid_v: present skid, then skid_v=0.
    - Else if inflight_v: if_pc=inflight_pc, if_inst=imem_rdata, if_valid=1.
    - Else: if_valid=0.
  - inflight_v and skid_v are never both 1 in a RUN cycle.
- stall=1 (RUN→STALL, or stay in STALL):
  - imem_en=0; fetch_pc holds; if_* hold unchanged.
  - If inflight_v: skid_inst=imem_rdata, skid_pc=inflight_pc, skid_v=1.
  - inflight_v=0.
  - A depth-1 skid is sufficient because issue stops while stalled.
- STALL, stall=0: behaves as RUN for that cycle (skid presented first, new issue at fetch_pc) → RUN.
- pc_jump=1 (overrides stall):
  - fetch_pc=pc_target.
  - inflight_v=0, skid_v=0, if_valid=0.
  - imem_en=0 that cycle → RUN.
  - Target issued at edge k+1; if_valid=1 with if_pc=pc_target at edge k+2, where k is the jump edge.
  - The pre-jump stream never appears after edge k.
- work_ena falling mid-run: identical to rst except that registers keep clocking; restart begins at RESET_PC.
- No instruction is ever lost or duplicated across stall.
- Steady-state throughput is 1 instruction/cycle.

Test Plan:
- rst 2 cycles, then work_ena=1, imem model returns data=addr^32'hA5A5_0000 → if_valid first at edge 2; if_pc 0,4,8,12 on consecutive cycles, each with matching if_inst.
- Steady stream, stall=1 for 3 cycles while if_pc=8 → if_pc stays 8 with if_inst unchanged throughout the stall, and imem_en=0 during it. After release, if_pc goes 12, 16, … with no gap larger than 0 cycles, no duplicate and no skip.
- pc_jump=1, pc_target=0x100 while if_pc=8 and address 12 is in flight → if_valid=0 for edges k+1 and k+2's predecessor. At edge k+2, if_pc=0x100, then 0x104. PCs 12 and 16 never appear.
- pc_jump=1 and stall=1 in the same cycle with skid full → jump wins; skid discarded; if_pc=pc_target at edge k+2.
- work_ena dropped for 2 cycles mid-stream, then raised → if_valid=0 while low; restart at if_pc=0, 4, ….
- rst asserted during a stall with skid_v=1 → all outputs 0 next edge. After release and re-enable, the first instruction is if_pc=RESET_PC, with no stale skid output.
- fetch_pc=2^32−4 → next if_pc=0 (wrap).
